// File: rtl/irq_axil_arbiter_if.sv
// Command/response bundle between irq_axil_arbiter (master) and the AXI-lite master adaptor (slave).
interface irq_axil_arbiter_if #(
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32
);
  logic [axil_addr_width_p-1:0] cmd_addr_o;
  logic                         cmd_v_o;
  logic                         cmd_yumi_i;
  logic                         cmd_wr_en_o;
  logic [1:0]                   cmd_data_size_o;
  logic [axil_data_width_p-1:0] cmd_wdata_o;
  logic                         resp_v_i;
  logic                         resp_ready_and_o;

  modport master (
    output cmd_addr_o, cmd_v_o, cmd_wr_en_o, cmd_data_size_o, cmd_wdata_o, resp_ready_and_o,
    input  cmd_yumi_i, resp_v_i
  );

  modport slave (
    input  cmd_addr_o, cmd_v_o, cmd_wr_en_o, cmd_data_size_o, cmd_wdata_o, resp_ready_and_o,
    output cmd_yumi_i, resp_v_i
  );
endinterface

// File: rtl/irq_axil_arbiter.sv
// Round-robin arbiter turning interrupt-line edges into single 32-bit PLIC register writes.
// Optional response timeout with sticky err_o: define IRQ_ARB_TIMEOUT_EN.
module irq_axil_arbiter #(
  parameter int          num_targets_p     = 4,
  parameter int          axil_addr_width_p = 32,
  parameter int          axil_data_width_p = 32,
  parameter int unsigned plic_base_addr_p  = 32'h0030_a000,
  parameter int unsigned target_stride_p   = 32'h0000_1000,
  parameter int unsigned timeout_cycles_p  = 32'd1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_targets_p-1:0] irq_r_i,
  irq_axil_arbiter_if.master       cmd_if,
  output logic [num_targets_p-1:0] pending_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int idx_w_lp = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;
  localparam logic [idx_w_lp-1:0] last_rst_lp = idx_w_lp'(num_targets_p - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10
  } state_e;

  function automatic logic [axil_addr_width_p-1:0] target_addr(input logic [idx_w_lp-1:0] idx);
    return axil_addr_width_p'(plic_base_addr_p)
         + axil_addr_width_p'(idx) * axil_addr_width_p'(target_stride_p);
  endfunction

  // Returns {found, index}; scan starts just after the last granted line and wraps.
  function automatic logic [idx_w_lp:0] rr_pick(input logic [num_targets_p-1:0] pend,
                                                 input logic [idx_w_lp-1:0]      last);
    logic                found;
    logic [idx_w_lp-1:0] idx;
    int                  cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= num_targets_p; k++) begin
      cand = (int'(last) + k) % num_targets_p;
      if (!found && pend[cand]) begin
        found = 1'b1;
        idx   = idx_w_lp'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_e                       state_r, state_n;
  logic [num_targets_p-1:0]     prev_r, pending_r;
  logic [num_targets_p-1:0]     change_s, grant_mask_s;
  logic [idx_w_lp-1:0]          last_r, pick_idx_s;
  logic                         pick_found_s, grant_v_s;
  logic                         cmd_v_r, busy_r;
  logic [axil_addr_width_p-1:0] cmd_addr_r;
  logic [axil_data_width_p-1:0] cmd_wdata_r;

`ifdef IRQ_ARB_TIMEOUT_EN
  localparam int tw_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [tw_lp-1:0] timeout_last_lp = tw_lp'(timeout_cycles_p - 1);
  logic [tw_lp-1:0] timer_r;
  logic             err_r;
  logic             timeout_s;
`endif

  assign change_s                   = irq_r_i ^ prev_r;
  assign {pick_found_s, pick_idx_s} = rr_pick(pending_r, last_r);
  assign grant_mask_s               = grant_v_s ? (num_targets_p'(1'b1) << pick_idx_s) : '0;

  // Next-state decode for the grant/issue/response handshake.
  always_comb begin
    state_n   = state_r;
    grant_v_s = 1'b0;
`ifdef IRQ_ARB_TIMEOUT_EN
    timeout_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          grant_v_s = 1'b1;
          state_n   = ISSUE;
        end else begin
          state_n   = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_if.cmd_yumi_i) begin
          state_n = WAIT_RESP;
        end else begin
          state_n = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (cmd_if.resp_v_i) begin
          state_n = IDLE;
        end
`ifdef IRQ_ARB_TIMEOUT_EN
        else if (timer_r == timeout_last_lp) begin
          state_n   = IDLE;
          timeout_s = 1'b1;
        end
`endif
        else begin
          state_n = WAIT_RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, edge history, pending set/clear (set wins) and the latched command.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      prev_r      <= '0;
      pending_r   <= '0;
      last_r      <= last_rst_lp;
      cmd_v_r     <= 1'b0;
      busy_r      <= 1'b0;
      cmd_addr_r  <= axil_addr_width_p'(plic_base_addr_p);
      cmd_wdata_r <= '0;
    end else begin
      state_r   <= state_n;
      prev_r    <= irq_r_i;
      pending_r <= (pending_r & ~grant_mask_s) | change_s;
      cmd_v_r   <= (state_n == ISSUE);
      busy_r    <= (state_n != IDLE);
      if (grant_v_s) begin
        last_r      <= pick_idx_s;
        cmd_addr_r  <= target_addr(pick_idx_s);
        cmd_wdata_r <= axil_data_width_p'(irq_r_i[pick_idx_s]);
      end else begin
        last_r      <= last_r;
        cmd_addr_r  <= cmd_addr_r;
        cmd_wdata_r <= cmd_wdata_r;
      end
    end
  end

`ifdef IRQ_ARB_TIMEOUT_EN
  // Response timer restarts on every accepted command; err_r is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if ((state_r == ISSUE) && cmd_if.cmd_yumi_i) begin
        timer_r <= '0;
      end else if (state_r == WAIT_RESP) begin
        timer_r <= timer_r + tw_lp'(1'b1);
      end else begin
        timer_r <= timer_r;
      end
      err_r <= err_r | timeout_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign cmd_if.cmd_addr_o       = cmd_addr_r;
  assign cmd_if.cmd_v_o          = cmd_v_r;
  assign cmd_if.cmd_wr_en_o      = 1'b1;
  assign cmd_if.cmd_data_size_o  = 2'b10;
  assign cmd_if.cmd_wdata_o      = cmd_wdata_r;
  assign cmd_if.resp_ready_and_o = 1'b1;
  assign pending_o               = pending_r;
  assign busy_o                  = busy_r;

endmodule

// File: tb/tb_irq_axil_arbiter.sv
// Directed scoreboard bench for irq_axil_arbiter; timeout scenario runs when IRQ_ARB_TIMEOUT_EN is defined.
module tb_irq_axil_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic [3:0] pending;
  logic       busy;
  logic       err;
  int         checks;
  int         errors;
  exp_t       exp_q[$];

  irq_axil_arbiter_if #(.axil_addr_width_p(32), .axil_data_width_p(32)) bus ();

  irq_axil_arbiter #(
    .num_targets_p    (4),
    .axil_addr_width_p(32),
    .axil_data_width_p(32),
    .plic_base_addr_p (32'h0030_a000),
    .target_stride_p  (32'h0000_1000),
    .timeout_cycles_p (32'd16)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .irq_r_i  (irq),
    .cmd_if   (bus),
    .pending_o(pending),
    .busy_o   (busy),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irq = 4'b0000;
    bus.cmd_yumi_i = 1'b0;
    bus.resp_v_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst cmd_v", 64'(bus.cmd_v_o), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst pending", 64'(pending), 64'd0);
    check("rst addr", 64'(bus.cmd_addr_o), 64'h30_a000);
    check("rst wdata", 64'(bus.cmd_wdata_o), 64'd0);
    check("rst err", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Wait for a command, compare it to the scoreboard head, stall, accept, then respond.
  task automatic serve(input string tag, input int stall, input bit toggle2, input int resp_wait);
    int   waited;
    exp_t e;
    waited = 0;
    while (bus.cmd_v_o !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " cmd_v"}, 64'(bus.cmd_v_o), 64'd1);
    check({tag, " sb nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " addr"}, 64'(bus.cmd_addr_o), 64'(e.addr));
      check({tag, " wdata"}, 64'(bus.cmd_wdata_o), 64'(e.data));
      check({tag, " wr_en"}, 64'(bus.cmd_wr_en_o), 64'd1);
      check({tag, " size"}, 64'(bus.cmd_data_size_o), 64'd2);
      check({tag, " busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < stall; i++) begin
        if (toggle2 && (i == 2 || i == 5 || i == 7)) irq[2] = ~irq[2];
        @(negedge clk);
        check({tag, " stall addr"}, 64'(bus.cmd_addr_o), 64'(e.addr));
        check({tag, " stall wdata"}, 64'(bus.cmd_wdata_o), 64'(e.data));
        check({tag, " stall v"}, 64'(bus.cmd_v_o), 64'd1);
      end
    end
    bus.cmd_yumi_i = 1'b1;
    @(negedge clk);
    bus.cmd_yumi_i = 1'b0;
    check({tag, " v after yumi"}, 64'(bus.cmd_v_o), 64'd0);
    check({tag, " busy wait"}, 64'(busy), 64'd1);
    repeat (resp_wait) @(negedge clk);
    bus.resp_v_i = 1'b1;
    @(negedge clk);
    bus.resp_v_i = 1'b0;
    check({tag, " busy idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    irq = 4'b0000;
    bus.cmd_yumi_i = 1'b0;
    bus.resp_v_i = 1'b0;

    // Single edge on line 0: pending at t+1, command at t+2.
    do_reset();
    irq = 4'b0001;
    push(32'h30_a000, 32'd1);
    @(negedge clk);
    check("single pend t+1", 64'(pending), 64'h1);
    check("single v t+1", 64'(bus.cmd_v_o), 64'd0);
    @(negedge clk);
    check("single v t+2", 64'(bus.cmd_v_o), 64'd1);
    check("single pend clr", 64'(pending), 64'h0);
    serve("single", 0, 1'b0, 2);

    // Fairness: all four rise together, then line 0 toggles twice and waits behind 1..3.
    do_reset();
    irq = 4'b1111;
    push(32'h30_a000, 32'd1);
    push(32'h30_b000, 32'd1);
    push(32'h30_c000, 32'd1);
    push(32'h30_d000, 32'd1);
    @(negedge clk);
    check("fair pend all", 64'(pending), 64'hf);
    serve("fair0", 0, 1'b0, 1);
    check("fair pend 123", 64'(pending), 64'he);
    irq[0] = 1'b0;
    @(negedge clk);
    irq[0] = 1'b1;
    push(32'h30_a000, 32'd1);
    serve("fair1", 0, 1'b0, 1);
    serve("fair2", 0, 1'b0, 1);
    serve("fair3", 0, 1'b0, 1);
    serve("fair0b", 0, 1'b0, 1);
    check("fair pend empty", 64'(pending), 64'h0);

    // Stall: line 2 toggles while its command waits for acceptance.
    do_reset();
    irq = 4'b0100;
    push(32'h30_c000, 32'd1);
    serve("stall", 10, 1'b1, 0);
    check("stall repend", 64'(pending), 64'h4);
    push(32'h30_c000, 32'd0);
    serve("stall2", 0, 1'b0, 0);
    check("stall pend empty", 64'(pending), 64'h0);

    // Set-wins: line 1 changes on the very edge it is granted.
    do_reset();
    irq = 4'b0010;
    push(32'h30_b000, 32'd0);
    push(32'h30_b000, 32'd0);
    @(negedge clk);
    check("setwin pend", 64'(pending), 64'h2);
    irq = 4'b0000;
    @(negedge clk);
    check("setwin v", 64'(bus.cmd_v_o), 64'd1);
    check("setwin pend kept", 64'(pending), 64'h2);
    serve("setwin1", 0, 1'b0, 0);
    serve("setwin2", 0, 1'b0, 0);
    check("setwin pend empty", 64'(pending), 64'h0);

    // Reset while waiting for a response with two lines still pending.
    do_reset();
    irq = 4'b0111;
    repeat (2) @(negedge clk);
    check("rmid v", 64'(bus.cmd_v_o), 64'd1);
    bus.cmd_yumi_i = 1'b1;
    @(negedge clk);
    bus.cmd_yumi_i = 1'b0;
    check("rmid busy", 64'(busy), 64'd1);
    check("rmid pend", 64'(pending), 64'h6);
    reset = 1'b1;
    irq = 4'b0000;
    @(negedge clk);
    check("rmid busy0", 64'(busy), 64'd0);
    check("rmid pend0", 64'(pending), 64'h0);
    check("rmid v0", 64'(bus.cmd_v_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.resp_v_i = 1'b1;
    @(negedge clk);
    bus.resp_v_i = 1'b0;
    check("stray busy", 64'(busy), 64'd0);
    check("stray v", 64'(bus.cmd_v_o), 64'd0);
    @(negedge clk);
    check("stray busy2", 64'(busy), 64'd0);

`ifdef IRQ_ARB_TIMEOUT_EN
    // No response: err_o rises after 16 cycles in WAIT_RESP and a late response is ignored.
    do_reset();
    irq = 4'b1000;
    repeat (2) @(negedge clk);
    check("to v", 64'(bus.cmd_v_o), 64'd1);
    check("to addr", 64'(bus.cmd_addr_o), 64'h30_d000);
    bus.cmd_yumi_i = 1'b1;
    @(negedge clk);
    bus.cmd_yumi_i = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check("to err early", 64'(err), 64'd0);
      @(negedge clk);
    end
    check("to busy last", 64'(busy), 64'd1);
    check("to err last", 64'(err), 64'd0);
    @(negedge clk);
    check("to err set", 64'(err), 64'd1);
    check("to busy0", 64'(busy), 64'd0);
    bus.resp_v_i = 1'b1;
    @(negedge clk);
    bus.resp_v_i = 1'b0;
    check("to late err", 64'(err), 64'd1);
    check("to late busy", 64'(busy), 64'd0);
`else
    check("err tied", 64'(err), 64'd0);
`endif

    check("sb drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
